// File: rtl/vram_arbiter.sv
// vram_arbiter -- shares the single-port synchronous VRAM between scanout
// fetch and the CPU bus. Video has priority. The CPU is serviced in idle slots
// through a req/ack handshake.
//
// Optional feature macro: VRAM_ARB_STARVE_EN
//   When defined, a CPU request that has waited STARVE_LIMIT cycles takes the
//   next slot even if video is requesting. The displaced video word is
//   reported on vid_miss.
//   When undefined, video priority is strict and vid_miss is tied low.
//
// Ports
//   clk, reset_n                         clock, async active-low reset
//   vid_req, vid_addr                    video fetch request (1-cycle pulse)
//   vid_valid, vid_data, vid_miss        video return path (pulses at t+2)
//   cpu_req, cpu_we, cpu_addr, cpu_wdata CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata                   CPU completion pulse and read data
//   mem_addr, mem_we, mem_wdata          registered VRAM command
//   mem_rdata                            VRAM read data, 1 cycle after address
module vram_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 15,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_miss,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    C_IDLE   = 3'd0,
    C_WAIT   = 3'd1,
    C_ISSUED = 3'd2,
    C_ACK    = 3'd3,
    C_DONE   = 3'd4
  } cpu_state_t;

  cpu_state_t state_q, state_d;

  logic cpu_wait_req;
  logic force_cpu;
  logic cpu_grant;
  logic vid_issue;
  logic vid_vld_p1, vid_vld_p2;
  logic cpu_rd_p1;

  assign cpu_wait_req = (state_q == C_WAIT) && cpu_req;

`ifdef VRAM_ARB_STARVE_EN
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             miss_p1, miss_p2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign force_cpu = cpu_wait_req && (starve_cnt == LIMIT_C);

  // Counts ungranted cycles spent in C_WAIT; any exit from C_WAIT clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if ((state_q == C_WAIT) && cpu_req && !cpu_grant) begin
      starve_cnt <= sat_inc(starve_cnt);
    end else begin
      starve_cnt <= '0;
    end
  end

  // Dropped video word travels alongside where its vid_valid would have been.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miss_p1 <= 1'b0;
      miss_p2 <= 1'b0;
    end else begin
      miss_p1 <= vid_req && force_cpu;
      miss_p2 <= miss_p1;
    end
  end

  assign vid_miss = miss_p2;
`else
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  logic unused_cfg;
  assign unused_cfg = ^LIMIT_C;
  assign force_cpu  = 1'b0;
  assign vid_miss   = 1'b0;
`endif

  assign cpu_grant = cpu_wait_req && (force_cpu || !vid_req);
  assign vid_issue = vid_req && !force_cpu;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= C_IDLE;
    else          state_q <= state_d;
  end

  // C_DONE holds off a still-asserted request so it is not serviced twice.
  always_comb begin
    state_d = state_q;
    cpu_ack = 1'b0;
    case (state_q)
      C_IDLE:   if (cpu_req) state_d = C_WAIT;
      C_WAIT: begin
        if (!cpu_req)      state_d = C_IDLE;
        else if (cpu_grant) state_d = C_ISSUED;
      end
      C_ISSUED: state_d = C_ACK;
      C_ACK: begin
        cpu_ack = 1'b1;
        state_d = C_DONE;
      end
      C_DONE:   if (!cpu_req) state_d = C_IDLE;
      default:  state_d = C_IDLE;
    endcase
  end

  // ---- stage p1: registered VRAM command ----
  // Outputs must read zero in reset, so the command registers are reset too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      vid_vld_p1 <= 1'b0;
      cpu_rd_p1  <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      vid_vld_p1 <= vid_issue;
      if (vid_issue) begin
        mem_addr <= vid_addr;
      end else if (cpu_grant) begin
        mem_addr  <= cpu_addr;
        mem_we    <= cpu_we;
        cpu_rd_p1 <= !cpu_we;
        if (cpu_we) mem_wdata <= cpu_wdata;
      end
    end
  end

  // ---- stage p2: VRAM data returns ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vid_vld_p2 <= 1'b0;
    else          vid_vld_p2 <= vid_vld_p1;
  end

  assign vid_valid = vid_vld_p2;
  assign vid_data  = vid_vld_p2 ? mem_rdata : '0;
  assign cpu_rdata = (cpu_ack && cpu_rd_p1) ? mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam int LIMIT  = 15;
`ifdef VRAM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              vid_req = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic              vid_valid, vid_miss, cpu_ack, mem_we;
  logic [DATA_W-1:0] vid_data, cpu_rdata, mem_wdata;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0, mem_addr;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] mem_rdata = '0;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid),
    .vid_data(vid_data), .vid_miss(vid_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a);
    logic [12:0] av;
    av = a[12:0];
    return av[7:0] ^ 8'h5A;
  endfunction

  // VRAM macro stand-in: synchronous single port, read returns old data.
  logic [7:0] vram [0:8191];
  initial for (int i = 0; i < 8192; i++) vram[i] = init_val(i);
  always @(posedge clk) begin
    if (mem_we) vram[mem_addr] <= mem_wdata;
    mem_rdata <= vram[mem_addr];
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: schedules, per edge number, what each output must show.
  int          ecnt = 0;
  bit          m_wait, m_block, pw;
  int          m_waited, m_gedge;
  logic [12:0] m_addr, pw_a;
  logic [7:0]  m_wdata, pw_d;
  logic [7:0]  shadow [0:8191];
  bit          e_we   [int];
  logic [7:0]  e_vd   [int];
  bit          e_miss [int];
  logic [7:0]  e_rd   [int];
  initial for (int i = 0; i < 8192; i++) shadow[i] = init_val(i);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_we.delete(); e_vd.delete(); e_miss.delete(); e_rd.delete();
      m_wait = 0; m_block = 0; pw = 0; m_waited = 0;
      m_addr = '0; m_wdata = '0;
    end else begin
      bit frc, grant;
      ecnt++;
      if (pw) begin shadow[pw_a] = pw_d; pw = 0; end
      frc   = STARVE && m_wait && cpu_req && (m_waited == LIMIT);
      grant = m_wait && cpu_req && (frc || !vid_req);
      if (vid_req && !frc) begin
        m_addr = vid_addr;
        e_vd[ecnt+1] = shadow[vid_addr];
      end
      if (vid_req && frc) e_miss[ecnt+1] = 1;
      if (grant) begin
        m_addr  = cpu_addr;
        m_gedge = ecnt;
        if (cpu_we) begin
          e_we[ecnt] = 1; m_wdata = cpu_wdata;
          pw = 1; pw_a = cpu_addr; pw_d = cpu_wdata;
          e_rd[ecnt+1] = 8'h00;
        end else begin
          e_rd[ecnt+1] = shadow[cpu_addr];
        end
      end
      if (m_wait) begin
        if (grant)        begin m_wait = 0; m_block = 1; end
        else if (!cpu_req) m_wait = 0;
        else              m_waited++;
      end else if (m_block) begin
        if (ecnt >= m_gedge + 3 && !cpu_req) m_block = 0;
      end else if (cpu_req) begin
        m_wait = 1; m_waited = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("mem_we", mem_we, e_we.exists(ecnt));
    chk("mem_addr", mem_addr, m_addr);
    if (mem_we) chk("mem_wdata", mem_wdata, m_wdata);
    chk("vid_valid", vid_valid, e_vd.exists(ecnt));
    chk("vid_data", vid_data, e_vd.exists(ecnt) ? e_vd[ecnt] : 8'h00);
    chk("vid_miss", vid_miss, e_miss.exists(ecnt));
    chk("cpu_ack", cpu_ack, e_rd.exists(ecnt));
    chk("cpu_rdata", cpu_rdata, e_rd.exists(ecnt) ? e_rd[ecnt] : 8'h00);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(output logic [7:0] rd);
    bit ok;
    ok = 0; rd = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (cpu_ack) begin rd = cpu_rdata; ok = 1; break; end
    end
    chk("ack_timeout", ok, 1'b1);
  endtask

  task automatic cpu_access(input logic we, input logic [12:0] a, input logic [7:0] d,
                            output logic [7:0] rd);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    wait_ack(rd);
    cpu_req = 0;
    tick(); tick();
  endtask

  initial begin
    logic [7:0] rd;
    int acks, misses;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int acks, misses;
    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      vid_req = 1'($urandom_range(0, 1)); vid_addr = 13'($urandom);
      cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 13'($urandom); cpu_wdata = 8'($urandom);
      tick();
      chk("rst_outs", {vid_valid, vid_miss, cpu_ack, mem_we, vid_data, cpu_rdata}, 0);
      chk("rst_mem", {mem_addr, mem_wdata}, 0);
    end
    vid_req = 0; cpu_req = 0; cpu_we = 0;
    reset_n = 1;
    tick();

    // First video fetch
    vid_req = 1; vid_addr = 13'h0123;
    tick();
    vid_req = 0;
    chk("t1_mem_addr", mem_addr, 13'h0123);
    tick();
    chk("t1_vid_valid", vid_valid, 1'b1);
    chk("t1_vid_data", vid_data, 8'h79);

    // CPU write then read on an idle bus
    cpu_req = 1; cpu_we = 1; cpu_addr = 13'h1000; cpu_wdata = 8'hA5;
    tick();
    tick();
    chk("t2_mem_we", mem_we, 1'b1);
    chk("t2_mem_addr", mem_addr, 13'h1000);
    chk("t2_mem_wdata", mem_wdata, 8'hA5);
    tick();
    chk("t2_we_once", mem_we, 1'b0);
    chk("t2_ack", cpu_ack, 1'b1);
    cpu_req = 0;
    tick(); tick();
    cpu_access(1'b0, 13'h1000, 8'h00, rd);
    chk("t2_rdata", rd, 8'hA5);

    // Simultaneous video and CPU request
    vid_req = 1; vid_addr = 13'h0200;
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h1000;
    tick();
    vid_req = 0;
    chk("t3_vid_first", mem_addr, 13'h0200);
    tick();
    chk("t3_cpu_next", mem_addr, 13'h1000);
    chk("t3_vid_valid", vid_valid, 1'b1);
    chk("t3_vid_data", vid_data, 8'h5A);
    chk("t3_no_ack_yet", cpu_ack, 1'b0);
    tick();
    chk("t3_ack", cpu_ack, 1'b1);
    chk("t3_rdata", cpu_rdata, 8'hA5);
    cpu_req = 0;
    tick(); tick();

    // Held request acknowledged once; re-request after one low cycle
    cpu_req = 1; cpu_we = 1; cpu_addr = 13'h0050; cpu_wdata = 8'h3C;
    acks = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); #1;
      acks += int'(cpu_ack);
      @(posedge clk); #1;
    end
    chk("t4_single_ack", acks, 1);
    cpu_req = 0;
    tick();
    cpu_access(1'b0, 13'h0050, 8'h00, rd);
    chk("t4_second_rdata", rd, 8'h3C);

    // Continuous video with a pending CPU read
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0050;
    acks = 0; misses = 0; rd = '0;
    for (int i = 0; i < 40; i++) begin
      vid_req = 1; vid_addr = 13'h0400 + 13'(i);
      @(negedge clk); #1;
      if (cpu_ack) rd = cpu_rdata;
      acks += int'(cpu_ack);
      misses += int'(vid_miss);
      @(posedge clk); #1;
    end
    vid_req = 0;
`ifdef VRAM_ARB_STARVE_EN
    chk("t5_forced_ack", acks, 1);
    chk("t5_miss", misses, 1);
    chk("t5_rdata", rd, 8'h3C);
    cpu_req = 0;
    tick(); tick();
`else
    chk("t5_starved", acks, 0);
    chk("t5_no_miss", misses, 0);
    wait_ack(rd);
    chk("t5_late_rdata", rd, 8'h3C);
    cpu_req = 0;
    tick(); tick();
`endif

    // Async reset while a write is issued
    cpu_req = 1; cpu_we = 1; cpu_addr = 13'h0060; cpu_wdata = 8'hEE;
    tick();
    tick();
    chk("t6_we_issued", mem_we, 1'b1);
    #2;
    reset_n = 0;
    #1;
    chk("t6_we_drop", mem_we, 1'b0);
    chk("t6_addr_clr", mem_addr, 13'h0000);
    cpu_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_ack", cpu_ack, 1'b0);
    end
    reset_n = 1;
    tick();
    cpu_access(1'b0, 13'h0060, 8'h00, rd);
    chk("t6_not_written", rd, 8'h3A);

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
